gbsha_fir_out_stage: RTL

Output conditioning stage that sits directly downstream of the FIR multiply/accumulate core. It consumes full-precision unsigned product words and rounds them (round-half-up, right shift) to the pin width, saturating on overflow. Results are buffered in a small first-word-fall-through FIFO with a valid/ready handshake toward the pin driver. It also keeps saturation and peak statistics for bring-up.

---
 rtl/gbsha_fir_out_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/gbsha_fir_out_stage.sv
// Output conditioning stage: rounds/saturates FIR products to pin width, buffers them
// in a first-word-fall-through FIFO and tracks saturation/peak statistics.
module gbsha_fir_out_stage #(
   parameter int unsigned BW_product = 12,
   parameter int unsigned BW_out     = 8,
   parameter int unsigned SHIFT      = 4,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic [BW_product-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [BW_out-1:0]     out_data,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      sat_count,
   output logic [BW_out-1:0]     peak
);

   localparam int unsigned SUM_W  = BW_product + 1;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned OCC_W  = PTR_W + 1;
   localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [SUM_W-1:0] RND     = (SHIFT > 0) ? (SUM_W'(1) << RND_SH) : '0;
   localparam logic [SUM_W-1:0] OUT_MAX = SUM_W'({BW_out{1'b1}});

   logic [BW_out-1:0] mem_q [DEPTH];
   logic [BW_out-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic [CNT_W-1:0]  sat_count_q, sat_count_d;
   logic [BW_out-1:0] peak_q, peak_d;

   logic [SUM_W-1:0]  sum;
   logic [SUM_W-1:0]  rounded;
   logic              conv_sat;
   logic [BW_out-1:0] conv_val;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  sat_base;
   logic [BW_out-1:0] peak_base;

   // Round-half-up then shift; anything above the pin range clamps to all ones.
   always_comb begin
      sum      = SUM_W'(in_data) + RND;
      rounded  = sum >> SHIFT;
      conv_sat = (rounded > OUT_MAX);
      conv_val = conv_sat ? '1 : rounded[BW_out-1:0];
   end

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      sat_count_d = sat_count_q;
      peak_d      = peak_q;
      sat_base    = clear ? '0 : sat_count_q;
      peak_base   = clear ? '0 : peak_q;

      push = in_valid && !full_q;
      pop  = out_ready && !empty_q;

      if (push) begin
         mem_d[wr_ptr_q] = conv_val;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + OCC_W'(1);
         2'b01:   count_d = count_q - OCC_W'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == OCC_W'(DEPTH));
      empty_d = (count_d == '0);

      // A clear on the same edge as an accept restarts statistics from that word.
      sat_count_d = sat_base;
      peak_d      = peak_base;
      if (push) begin
         if (conv_sat && (sat_base != '1)) begin
            sat_count_d = sat_base + CNT_W'(1);
         end
         if (conv_val > peak_base) begin
            peak_d = conv_val;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         sat_count_q <= '0;
         peak_q      <= '0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         sat_count_q <= sat_count_d;
         peak_q      <= peak_d;
      end
   end

   assign in_ready  = !full_q;
   assign out_valid = !empty_q;
   assign out_data  = mem_q[rd_ptr_q];
   assign sat_count = sat_count_q;
   assign peak      = peak_q;

endmodule
